led_nios2_qsys_oci_trace_capture: RTL
=====================================

// Module: led_nios2_qsys_oci_trace_capture
// PURPOSE
// Parametrised capture buffer for Nios II OCI debug-trace (DCT) frames, sitting beside the OCI
//   in the qsys simulation/debug fabric. Non-empty frames are stored into a circular buffer with
//   selectable stop-on-full or overwrite-oldest policy. Frames drain to a host over valid/ready.
// Signals end-of-test once a requested flush has emptied the buffer.
// PARAMETERS
// DCT_W      30  width of dct_buffer frame payload
// CNT_W      4   width of dct_count (number of valid nibbles in frame)
// DEPTH      16  buffer entries; power of two, >=2
// WRAP_MODE  0   0 = stop-on-full (drop new, count overflow); 1 = overwrite oldest
// OVF_W      16  width of saturating overflow counter
// PORTS
// clk            in   1              single clock; all logic on rising edge
// reset_n        in   1              asynchronous, active-low reset
// cap_en         in   1              capture enable
// dct_buffer     in   DCT_W          trace frame payload
// dct_count      in   CNT_W          valid nibble count; 0 = no frame this cycle
// test_ending    in   1              1-cycle pulse: stop capture, begin drain
// rd_valid       out  1              rd_data holds oldest stored frame
// rd_ready       in   1              consumer accepts rd_data when rd_valid&&rd_ready
// rd_data        out  CNT_W+DCT_W    {count, payload} of oldest frame
// fill_level     out  $clog2(DEPTH)+1  entries currently stored
// overflow_cnt   out  OVF_W          frames dropped/overwritten, saturates at all-ones
// test_has_ended out  1              sticky: drain complete
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE, pointers 0, fill_level 0, rd_valid 0,
//   overflow_cnt 0, test_has_ended 0; rd_data don't-care while rd_valid=0.
// - FSM: IDLE -> CAPTURE when cap_en=1. CAPTURE -> IDLE when cap_en=0 (buffer retained).
//   IDLE/CAPTURE -> DRAIN on test_ending. DRAIN -> DONE when fill_level=0 (same cycle check
//   after any pop). DONE: test_has_ended=1, held until reset; ignores all further input.
// - Push: in CAPTURE only, when dct_count!=0; frame {dct_count,dct_buffer} written same edge.
//   Stored frame visible at rd_data/rd_valid the cycle after push (1-cycle latency).
// - Pop: rd_valid&&rd_ready; allowed in IDLE, CAPTURE, DRAIN. rd_data = mem[rd_ptr]
//   combinational; rd_valid = (fill_level!=0) && state!=DONE... DONE implies empty.
// - Full, WRAP_MODE=0: push without pop is dropped, overflow_cnt+1; push with pop accepted
//   (pop frees slot same edge), fill unchanged.
// - Full, WRAP_MODE=1: push without pop overwrites oldest, rd_ptr advances, overflow_cnt+1,
//   fill stays DEPTH. Push with pop: consumer receives current oldest, new frame written,
//   no overflow count.
// - Empty: pop impossible (rd_valid=0); simultaneous push into empty -> fill 1.
// - Pointers log2(DEPTH) bits, wrap naturally; fill_level via separate counter 0..DEPTH.
// - test_ending in same cycle as push: push suppressed (transition wins). test_ending in
//   DRAIN/DONE ignored. test_ending with empty buffer -> DRAIN then DONE next cycle.
// - Reset mid-drain: all state cleared, stored frames lost, test_has_ended returns 0.
// - overflow_cnt saturates; never wraps.
// STRUCTURE
// - Shared header led_nios2_qsys_oci_trace_pkg.vh: state encodings (IDLE=0, CAPTURE=1,
//   DRAIN=2, DONE=3), default DCT_W/CNT_W, frame-width macro.
// - Sub-module led_nios2_qsys_oci_trace_fifo: DEPTH x (CNT_W+DCT_W) storage, wr/rd pointers,
//   fill counter, overwrite input; top holds FSM, push/drop decision, overflow counter.
// TESTING
// 1 Reset, cap_en=1, push 3 frames count=4 payloads 1,2,3, rd_ready=1 -> rd_data
//   {4,1},{4,2},{4,3} in order, each 1 cycle after its push; fill_level returns to 0.
// 2 WRAP_MODE=0, DEPTH=4, rd_ready=0, push 6 frames A..F -> fill 4, overflow_cnt=2,
//   drain yields A,B,C,D.
// 3 WRAP_MODE=1, DEPTH=4, rd_ready=0, push A..F -> overflow_cnt=2, drain yields C,D,E,F.
// 4 Push frames with dct_count=0 interleaved -> not stored, fill_level unchanged.
// 5 5 frames stored, pulse test_ending with concurrent push -> push dropped; rd_ready=1;
//   test_has_ended rises the cycle fill_level reaches 0, stays 1; later pushes ignored.
// 6 Full buffer, push+pop same cycle both modes -> fill stays DEPTH, overflow_cnt unchanged;
//   assert reset_n low mid-drain -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/led_nios2_qsys_oci_trace_capture_pkg.sv
// Shared types and defaults for the Nios II OCI trace-capture buffer.
package led_nios2_qsys_oci_trace_capture_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StDrain   = 2'd2,
    StDone    = 2'd3
  } trace_state_e;

  localparam int unsigned DefDctW  = 30;
  localparam int unsigned DefCntW  = 4;
  localparam int unsigned DefDepth = 16;
  localparam int unsigned DefOvfW  = 16;

  // Stored frame is {dct_count, dct_buffer}.
  function automatic int unsigned frame_w(int unsigned dct_w, int unsigned cnt_w);
    return dct_w + cnt_w;
  endfunction

endpackage

// File: rtl/led_nios2_qsys_oci_trace_capture_if.sv
// Trace-source / host-drain signal bundle for the OCI trace-capture buffer.
interface led_nios2_qsys_oci_trace_capture_if
  import led_nios2_qsys_oci_trace_capture_pkg::*;
#(
  parameter int unsigned DCT_W = DefDctW,
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned OVF_W = DefOvfW
);
  localparam int unsigned FrameW = frame_w(DCT_W, CNT_W);
  localparam int unsigned FillW  = $clog2(DEPTH) + 1;

  logic              cap_en;
  logic [DCT_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              test_ending;
  logic              rd_valid;
  logic              rd_ready;
  logic [FrameW-1:0] rd_data;
  logic [FillW-1:0]  fill_level;
  logic [OVF_W-1:0]  overflow_cnt;
  logic              test_has_ended;

  modport slave (
    input  cap_en, dct_buffer, dct_count, test_ending, rd_ready,
    output rd_valid, rd_data, fill_level, overflow_cnt, test_has_ended
  );

  modport master (
    output cap_en, dct_buffer, dct_count, test_ending, rd_ready,
    input  rd_valid, rd_data, fill_level, overflow_cnt, test_has_ended
  );

endinterface

// File: rtl/led_nios2_qsys_oci_trace_fifo.sv
// Circular frame store with separate fill counter; overwrite advances the read pointer so the
// oldest entry is replaced while the buffer stays full.
module led_nios2_qsys_oci_trace_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned FillW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_overwrite,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [FillW-1:0] o_fill,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [FillW-1:0] r_fill;

  // Storage carries no reset; contents are only observable while r_fill is non-zero.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop || i_overwrite) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (i_push && !i_pop && !i_overwrite) begin
        r_fill <= r_fill + FillW'(1);
      end else if (i_pop && !i_push) begin
        r_fill <= r_fill - FillW'(1);
      end
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_fill  = r_fill;
  assign o_full  = (r_fill == FillW'(DEPTH));
  assign o_empty = (r_fill == '0);

  a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n) !(i_pop && o_empty));
  a_no_overflow  : assert property (@(posedge clk) disable iff (!reset_n)
                                    !(i_push && o_full && !i_pop && !i_overwrite));
  a_overwrite_full : assert property (@(posedge clk) disable iff (!reset_n)
                                      !(i_overwrite && (!o_full || !i_push || i_pop)));

endmodule

// File: rtl/led_nios2_qsys_oci_trace_capture.sv
// Nios II OCI trace capture: control FSM, push/drop policy and saturating overflow count around
// a circular frame buffer that drains to the host over valid/ready.
module led_nios2_qsys_oci_trace_capture
  import led_nios2_qsys_oci_trace_capture_pkg::*;
#(
  parameter int unsigned DCT_W     = DefDctW,
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned WRAP_MODE = 0,
  parameter int unsigned OVF_W     = DefOvfW
) (
  input logic clk,
  input logic reset_n,
  led_nios2_qsys_oci_trace_capture_if.slave trace_bus
);

  localparam int unsigned FrameW = frame_w(DCT_W, CNT_W);
  localparam int unsigned FillW  = $clog2(DEPTH) + 1;

  trace_state_e     r_state;
  logic             r_test_has_ended;
  logic [OVF_W-1:0] r_overflow_cnt;

  logic [FillW-1:0]  w_fill;
  logic [FrameW-1:0] w_rdata;
  logic [FrameW-1:0] w_wdata;
  logic              w_full;
  logic              w_empty;
  logic              w_rd_valid;
  logic              w_pop;
  logic              w_push_req;
  logic              w_ovf_inc;
  logic              w_wr_en;
  logic              w_overwrite;
  logic              w_drain_empty;

  assign w_rd_valid = !w_empty && (r_state != StDone);
  assign w_pop      = w_rd_valid && trace_bus.rd_ready;

  // A concurrent test_ending wins over the frame arriving in the same cycle.
  assign w_push_req = (r_state == StCapture) && !trace_bus.test_ending &&
                      (trace_bus.dct_count != '0);

  // A simultaneous pop frees a slot on the same edge, so only push-without-pop on full loses data.
  assign w_ovf_inc   = w_push_req && w_full && !w_pop;
  assign w_wr_en     = w_push_req && (!w_ovf_inc || (WRAP_MODE != 0));
  assign w_overwrite = w_wr_en && w_ovf_inc;
  assign w_wdata     = {trace_bus.dct_count, trace_bus.dct_buffer};

  // No pushes happen in drain, so the next fill is the current fill minus any pop.
  assign w_drain_empty = (w_fill == '0) || ((w_fill == FillW'(1)) && w_pop);

  led_nios2_qsys_oci_trace_fifo #(
    .WIDTH (FrameW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_wr_en),
    .i_pop       (w_pop),
    .i_overwrite (w_overwrite),
    .i_wdata     (w_wdata),
    .o_rdata     (w_rdata),
    .o_fill      (w_fill),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= StIdle;
      r_test_has_ended <= 1'b0;
      r_overflow_cnt   <= '0;
    end else begin
      if (w_ovf_inc && (r_overflow_cnt != '1)) begin
        r_overflow_cnt <= r_overflow_cnt + OVF_W'(1);
      end
      unique case (r_state)
        StIdle: begin
          if (trace_bus.test_ending) begin
            r_state <= StDrain;
          end else if (trace_bus.cap_en) begin
            r_state <= StCapture;
          end
        end
        StCapture: begin
          if (trace_bus.test_ending) begin
            r_state <= StDrain;
          end else if (!trace_bus.cap_en) begin
            r_state <= StIdle;
          end
        end
        StDrain: begin
          if (w_drain_empty) begin
            r_state          <= StDone;
            r_test_has_ended <= 1'b1;
          end
        end
        StDone: begin
          r_test_has_ended <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign trace_bus.rd_valid       = w_rd_valid;
  assign trace_bus.rd_data        = w_rdata;
  assign trace_bus.fill_level     = w_fill;
  assign trace_bus.overflow_cnt   = r_overflow_cnt;
  assign trace_bus.test_has_ended = r_test_has_ended;

endmodule
